// File: rtl/instr_router_pkg.sv
// Shared types, constants and helpers for the instruction-side fetch router and its address decoder.
// The top level optionally captures the first unmapped fetch address when INSTR_ROUTER_ERR_CAPTURE_EN is defined.
package instr_router_pkg;

  localparam int MaxOutstandingLimit = 4;

  localparam logic [31:0] ErrRdata = 32'h0000_0000;

  localparam logic [31:0] RamBase = 32'h0010_0000;
  localparam logic [31:0] RamMask = 32'hFFFF_0000;
  localparam logic [31:0] DbgBase = 32'h1A11_0000;
  localparam logic [31:0] DbgMask = 32'hFFFF_0000;

  // Target index width; it must also hold NrTargets, the internal error pseudo-target.
  function automatic int tgt_idx_width(input int nr_targets);
    return (nr_targets < 1) ? 1 : $clog2(nr_targets + 1);
  endfunction

endpackage

// File: rtl/instr_addr_decode.sv
// Combinational base/mask address decoder with lowest-index priority.
// When no target matches, the decoder returns index NrTargets and asserts miss_o.
module instr_addr_decode
  import instr_router_pkg::*;
#(
  parameter int NrTargets = 2,
  parameter int AddrWidth = 32,
  parameter int IdxWidth  = tgt_idx_width(NrTargets)
) (
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic [NrTargets-1:0][AddrWidth-1:0] base_i,
  input  logic [NrTargets-1:0][AddrWidth-1:0] mask_i,
  output logic [IdxWidth-1:0]                 dec_o,
  output logic                                miss_o
);

  // The loop runs from the highest index down, so the lowest matching index is written last and wins.
  always_comb begin
    dec_o  = IdxWidth'(NrTargets);
    miss_o = 1'b1;
    for (int i = NrTargets - 1; i >= 0; i--) begin
      if ((addr_i & mask_i[i]) == base_i[i]) begin
        dec_o  = IdxWidth'(i);
        miss_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_router.sv
// Instruction-side router between the core fetch port and NrTargets fetch targets.
// Responses return in order; unmapped fetches get a 1-cycle error response.
// Define INSTR_ROUTER_ERR_CAPTURE_EN to capture the first faulting fetch address.
module instr_fetch_router
  import instr_router_pkg::*;
#(
  parameter int NrTargets      = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                host_req_i,
  output logic                                host_gnt_o,
  input  logic [AddrWidth-1:0]                host_addr_i,
  output logic                                host_rvalid_o,
  output logic [DataWidth-1:0]                host_rdata_o,
  output logic                                host_err_o,
  input  logic [NrTargets-1:0][AddrWidth-1:0] cfg_base_i,
  input  logic [NrTargets-1:0][AddrWidth-1:0] cfg_mask_i,
  output logic [NrTargets-1:0]                tgt_req_o,
  output logic [AddrWidth-1:0]                tgt_addr_o,
  input  logic [NrTargets-1:0]                tgt_gnt_i,
  input  logic [NrTargets-1:0]                tgt_rvalid_i,
  input  logic [NrTargets-1:0][DataWidth-1:0] tgt_rdata_i,
  input  logic [NrTargets-1:0]                tgt_err_i,
  output logic [AddrWidth-1:0]                err_addr_o,
  output logic                                err_valid_o,
  input  logic                                err_clr_i
);

  localparam int IdxW = tgt_idx_width(NrTargets);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0]      dec;
  logic                 miss;
  logic [IdxW-1:0]      cur_tgt_q;
  logic [CntW-1:0]      outst_q, outst_d;
  logic                 err_rvalid_q;
  logic                 ok, accept, tgt_resp;
  logic                 sel_gnt, sel_rvalid, sel_err;
  logic [DataWidth-1:0] sel_rdata;

  instr_addr_decode #(
    .NrTargets(NrTargets),
    .AddrWidth(AddrWidth),
    .IdxWidth (IdxW)
  ) u_decode (
    .addr_i(host_addr_i),
    .base_i(cfg_base_i),
    .mask_i(cfg_mask_i),
    .dec_o (dec),
    .miss_o(miss)
  );

  // A new target may only be addressed once all fetches to the current one have drained.
  // This keeps responses in order without a tag FIFO.
  assign ok = host_req_i && (outst_q < CntW'(MaxOutstanding)) &&
              ((outst_q == '0) || (dec == cur_tgt_q));

  // Grant comes from the decoded target and responses come from the owning target.
  // The error pseudo-target matches no loop index.
  always_comb begin
    sel_gnt    = 1'b0;
    sel_rvalid = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    tgt_req_o  = '0;
    for (int i = 0; i < NrTargets; i++) begin
      if (dec == IdxW'(i)) begin
        sel_gnt      = tgt_gnt_i[i];
        tgt_req_o[i] = ok;
      end
      if (cur_tgt_q == IdxW'(i)) begin
        sel_rvalid = tgt_rvalid_i[i];
        sel_err    = tgt_err_i[i];
        sel_rdata  = tgt_rdata_i[i];
      end
    end
  end

  assign accept     = ok && (miss || sel_gnt);
  assign host_gnt_o = accept;
  assign tgt_addr_o = host_addr_i;

  assign tgt_resp      = (outst_q != '0) && sel_rvalid;
  assign host_rvalid_o = err_rvalid_q || tgt_resp;
  assign host_err_o    = err_rvalid_q || (tgt_resp && sel_err);
  assign host_rdata_o  = tgt_resp     ? sel_rdata :
                         err_rvalid_q ? DataWidth'(ErrRdata) : '0;

  always_comb begin
    outst_d = outst_q;
    if (accept && !host_rvalid_o) begin
      outst_d = outst_q + CntW'(1);
    end else if (!accept && host_rvalid_o) begin
      outst_d = outst_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q      <= '0;
      cur_tgt_q    <= '0;
      err_rvalid_q <= 1'b0;
    end else begin
      outst_q      <= outst_d;
      err_rvalid_q <= accept && miss;
      if (accept) begin
        cur_tgt_q <= dec;
      end
    end
  end

`ifdef INSTR_ROUTER_ERR_CAPTURE_EN
  logic [AddrWidth-1:0] err_addr_q;
  logic                 err_valid_q;

  // A clear wins over a capture in the same cycle; only the first miss is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else if (err_clr_i) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else if (accept && miss && !err_valid_q) begin
      err_addr_q  <= host_addr_i;
      err_valid_q <= 1'b1;
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_valid_o = err_valid_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;
  assign err_addr_o     = '0;
  assign err_valid_o    = 1'b0;
`endif

`ifndef SYNTHESIS
  for (genvar g = 0; g < NrTargets; g++) begin : gen_spurious_chk
    SpuriousRvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      tgt_rvalid_i[g] |-> ((outst_q != '0) && (cur_tgt_q == IdxW'(g))));
  end
`endif

endmodule

// File: tb/tb_instr_fetch_router.sv
// Directed, table-driven bench for instr_fetch_router (2 targets: RAM and debug memory).
// Each row drives one cycle; the hand-written sequences cover capture clear, decode priority and mid-operation reset.
module tb_instr_fetch_router;
  import instr_router_pkg::*;

  localparam int NrT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
`ifdef INSTR_ROUTER_ERR_CAPTURE_EN
  localparam bit CapEn = 1'b1;
`else
  localparam bit CapEn = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   hostReq, hostGnt, hostRvalid, hostErr;
  logic [AW-1:0]          hostAddr;
  logic [DW-1:0]          hostRdata;
  logic [NrT-1:0][AW-1:0] cfgBase, cfgMask;
  logic [NrT-1:0]         tgtReq, tgtGnt, tgtRvalid, tgtErr;
  logic [AW-1:0]          tgtAddr;
  logic [NrT-1:0][DW-1:0] tgtRdata;
  logic [AW-1:0]          errAddr;
  logic                   errValid, errClr;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [1:0]  gnt, rv, terr;
    logic [31:0] rd0, rd1;
    logic        clr;
    logic        eGnt;
    logic [1:0]  eReq;
    logic        eRv;
    logic [31:0] eRdata;
    logic        eErr;
    logic        eCapV;
    logic [31:0] eCapA;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  instr_fetch_router #(
    .NrTargets(NrT), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(hostReq), .host_gnt_o(hostGnt), .host_addr_i(hostAddr),
    .host_rvalid_o(hostRvalid), .host_rdata_o(hostRdata), .host_err_o(hostErr),
    .cfg_base_i(cfgBase), .cfg_mask_i(cfgMask),
    .tgt_req_o(tgtReq), .tgt_addr_o(tgtAddr), .tgt_gnt_i(tgtGnt),
    .tgt_rvalid_i(tgtRvalid), .tgt_rdata_i(tgtRdata), .tgt_err_i(tgtErr),
    .err_addr_o(errAddr), .err_valid_o(errValid), .err_clr_i(errClr)
  );

  always #5 clk = ~clk;

  // capA is the capture address expected when the capture feature is built in; 0 means no capture.
  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic [1:0] gnt,
                              input logic [1:0] rv, input logic [1:0] terr,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic eGnt, input logic [1:0] eReq, input logic eRv,
                              input logic [31:0] eRdata, input logic eErr, input logic [31:0] capA);
    vec_t r;
    r.req = req; r.addr = addr; r.gnt = gnt; r.rv = rv; r.terr = terr;
    r.rd0 = rd0; r.rd1 = rd1; r.clr = 1'b0;
    r.eGnt = eGnt; r.eReq = eReq; r.eRv = eRv; r.eRdata = eRdata; r.eErr = eErr;
    r.eCapV = CapEn && (capA != 32'h0);
    r.eCapA = CapEn ? capA : 32'h0;
    return r;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic applyStimulus(input vec_t s);
    @(negedge clk);
    hostReq     = s.req;
    hostAddr    = s.addr;
    tgtGnt      = s.gnt;
    tgtRvalid   = s.rv;
    tgtErr      = s.terr;
    tgtRdata[0] = s.rd0;
    tgtRdata[1] = s.rd1;
    errClr      = s.clr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVector(input string tag, input vec_t s);
    checkOutput({tag, " gnt"},      32'(hostGnt),    32'(s.eGnt));
    checkOutput({tag, " tgt_req"},  32'(tgtReq),     32'(s.eReq));
    checkOutput({tag, " rvalid"},   32'(hostRvalid), 32'(s.eRv));
    checkOutput({tag, " rdata"},    hostRdata,       s.eRdata);
    checkOutput({tag, " err"},      32'(hostErr),    32'(s.eErr));
    checkOutput({tag, " err_valid"}, 32'(errValid),  32'(s.eCapV));
    checkOutput({tag, " err_addr"}, errAddr,         s.eCapA);
  endtask

  initial begin
    cfgBase[0] = RamBase; cfgMask[0] = RamMask;
    cfgBase[1] = DbgBase; cfgMask[1] = DbgMask;

    // Cycle-by-cycle table: idle, single fetch, full stall, target switch, target error, misses, backpressure.
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         0, 2'b00, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0080, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b01, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b01, 2'b00, 32'h0000_0013, 32'h0,         0, 2'b00, 1, 32'h0000_0013, 0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0000, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b01, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0004, 2'b11, 2'b00, 2'b00, 32'h5555_5555, 32'h0,         1, 2'b01, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0008, 2'b11, 2'b00, 2'b00, 32'h5555_5555, 32'h6666_6666, 0, 2'b00, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0008, 2'b11, 2'b01, 2'b00, 32'hAAAA_0001, 32'h0,         0, 2'b00, 1, 32'hAAAA_0001, 0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0008, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b01, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b01, 2'b00, 32'hAAAA_0002, 32'h0,         0, 2'b00, 1, 32'hAAAA_0002, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b01, 2'b00, 32'hAAAA_0003, 32'h0,         0, 2'b00, 1, 32'hAAAA_0003, 0, 32'h0));
    vecs.push_back(mk(1, 32'h0010_0000, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b01, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h1A11_0800, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         0, 2'b00, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h1A11_0800, 2'b11, 2'b01, 2'b00, 32'hBBBB_0000, 32'h0,         0, 2'b00, 1, 32'hBBBB_0000, 0, 32'h0));
    vecs.push_back(mk(1, 32'h1A11_0800, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b10, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b10, 2'b00, 32'h0,         32'hCCCC_0001, 0, 2'b00, 1, 32'hCCCC_0001, 0, 32'h0));
    vecs.push_back(mk(1, 32'h1A11_0000, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b10, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b10, 2'b10, 32'h0,         32'hDEAD_0000, 0, 2'b00, 1, 32'hDEAD_0000, 1, 32'h0));
    vecs.push_back(mk(1, 32'h4000_0000, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b00, 0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(1, 32'h5000_0000, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b00, 1, 32'h0,         1, 32'h4000_0000));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         0, 2'b00, 1, 32'h0,         1, 32'h4000_0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'h1A11_0000, 2'b01, 2'b00, 2'b00, 32'h0,     32'h0,         0, 2'b10, 0, 32'h0,         0, 32'h4000_0000));
    vecs.push_back(mk(1, 32'h1A11_0000, 2'b11, 2'b00, 2'b00, 32'h0,         32'h0,         1, 2'b10, 0, 32'h0,         0, 32'h4000_0000));
    vecs.push_back(mk(0, 32'h0,         2'b11, 2'b10, 2'b00, 32'h0,         32'h0000_1234, 0, 2'b00, 1, 32'h0000_1234, 0, 32'h4000_0000));

    rst = 1'b1;
    hostReq = 1'b0; hostAddr = '0; tgtGnt = 2'b11; tgtRvalid = '0; tgtErr = '0;
    tgtRdata = '0; errClr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset gnt",       32'(hostGnt),    32'h0);
    checkOutput("reset rvalid",    32'(hostRvalid), 32'h0);
    checkOutput("reset rdata",     hostRdata,       32'h0);
    checkOutput("reset err_valid", 32'(errValid),   32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVector($sformatf("row%0d", i), vecs[i]);
    end

    // Capture clear, then a clear coinciding with a new miss, then a fresh capture.
    v = mk(0, 32'h0, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 0, 2'b00, 0, 32'h0, 0, 32'h4000_0000);
    v.clr = 1'b1;
    applyStimulus(v); checkVector("clr0", v);
    v = mk(0, 32'h0, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 0, 2'b00, 0, 32'h0, 0, 32'h0);
    applyStimulus(v); checkVector("clr1", v);
    v = mk(1, 32'h6000_0000, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 0, 32'h0, 0, 32'h0);
    v.clr = 1'b1;
    applyStimulus(v); checkVector("clrprio0", v);
    v = mk(0, 32'h0, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 0, 2'b00, 1, 32'h0, 1, 32'h0);
    applyStimulus(v); checkVector("clrprio1", v);
    v = mk(1, 32'h7000_0000, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b00, 0, 32'h0, 0, 32'h0);
    applyStimulus(v); checkVector("recap0", v);
    v = mk(0, 32'h0, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 0, 2'b00, 1, 32'h0, 1, 32'h7000_0000);
    applyStimulus(v); checkVector("recap1", v);

    // Overlapping windows: both targets hit, target 0 must win.
    cfgBase[1] = RamBase;
    v = mk(1, 32'h0010_0040, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b01, 0, 32'h0, 0, 32'h7000_0000);
    applyStimulus(v); checkVector("prio0", v);
    v = mk(0, 32'h0, 2'b11, 2'b01, 2'b00, 32'h0000_0099, 32'h0, 0, 2'b00, 1, 32'h0000_0099, 0, 32'h7000_0000);
    applyStimulus(v); checkVector("prio1", v);
    cfgBase[1] = DbgBase;

    // Two fetches outstanding, then reset while target 0 still answers.
    v = mk(1, 32'h0010_0000, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b01, 0, 32'h0, 0, 32'h7000_0000);
    applyStimulus(v); checkVector("prerst0", v);
    v = mk(1, 32'h0010_0004, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b01, 0, 32'h0, 0, 32'h7000_0000);
    applyStimulus(v); checkVector("prerst1", v);
    @(negedge clk);
    rst = 1'b1; hostReq = 1'b0; tgtRvalid = 2'b01; tgtRdata[0] = 32'h0000_0077;
    #1;
    checkOutput("midrst rvalid",    32'(hostRvalid), 32'h0);
    checkOutput("midrst rdata",     hostRdata,       32'h0);
    checkOutput("midrst err_valid", 32'(errValid),   32'h0);
    @(negedge clk);
    checkOutput("midrst rvalid2",   32'(hostRvalid), 32'h0);
    rst = 1'b0; tgtRvalid = 2'b00;
    v = mk(1, 32'h1A11_0000, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1, 2'b10, 0, 32'h0, 0, 32'h0);
    applyStimulus(v); checkVector("postrst0", v);
    v = mk(0, 32'h0, 2'b11, 2'b10, 2'b00, 32'h0, 32'h0000_4321, 0, 2'b00, 1, 32'h0000_4321, 0, 32'h0);
    applyStimulus(v); checkVector("postrst1", v);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
